// File: rtl/pwm_fade_ctrl.sv
// Duty-cycle sequencer for the 8-bit PWM stage: ramps min->max, holds, ramps back, holds, and optionally loops.
// Optional build macro PWM_FADE_GAMMA_EN applies a square-law gamma curve to pwm_count.
module pwm_fade_ctrl #(
  parameter int DIV_W  = 16,
  parameter int HOLD_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [DIV_W-1:0]  step_div,
  input  logic [HOLD_W-1:0] hold_ticks,
  input  logic [7:0]        min_duty,
  input  logic [7:0]        max_duty,
  input  logic              loop_en,
  output logic [7:0]        pwm_count,
  output logic              busy,
  output logic              done,
  output logic              config_err
);

  typedef enum logic [2:0] {IDLE, UP, HOLD_HI, DOWN, HOLD_LO} state_t;

  state_t              state, state_nxt;
  logic [7:0]          duty, duty_nxt;
  logic [DIV_W-1:0]    presc;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [DIV_W-1:0]    div_s;
  logic [HOLD_W-1:0]   hold_s;
  logic [7:0]          min_s, max_s;
  logic                load, hold_inc, done_nxt, cfg_nxt;
  logic                tick, hold_end;
  logic [7:0]          duty_inc, duty_dec;

  assign tick     = (presc == div_s);
  assign hold_end = tick && (hold_cnt == hold_s);
  assign duty_inc = duty + 8'd1;
  assign duty_dec = duty - 8'd1;
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    duty_nxt  = duty;
    load      = 1'b0;
    hold_inc  = 1'b0;
    done_nxt  = 1'b0;
    cfg_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (stop) begin
          duty_nxt = 8'd0;
        end else if (start) begin
          if (min_duty < max_duty) begin
            load      = 1'b1;
            duty_nxt  = min_duty;
            state_nxt = UP;
          end else begin
            cfg_nxt = 1'b1;
          end
        end
      end
      UP: begin
        if (tick) begin
          duty_nxt = duty_inc;
          if (duty_inc == max_s) state_nxt = HOLD_HI;
        end
      end
      HOLD_HI: begin
        if (hold_end)  state_nxt = DOWN;
        else if (tick) hold_inc  = 1'b1;
      end
      DOWN: begin
        if (tick) begin
          duty_nxt = duty_dec;
          if (duty_dec == min_s) state_nxt = HOLD_LO;
        end
      end
      HOLD_LO: begin
        if (hold_end) begin
          if (loop_en) begin
            state_nxt = UP;
          end else begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end else if (tick) begin
          hold_inc = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Abort overrides any progress made this cycle and suppresses done.
    if (stop && (state != IDLE)) begin
      state_nxt = IDLE;
      duty_nxt  = 8'd0;
      done_nxt  = 1'b0;
      hold_inc  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      duty       <= 8'd0;
      presc      <= '0;
      hold_cnt   <= '0;
      done       <= 1'b0;
      config_err <= 1'b0;
    end else begin
      state      <= state_nxt;
      duty       <= duty_nxt;
      done       <= done_nxt;
      config_err <= cfg_nxt;
      // Prescaler restarts on every state entry so each phase begins with a full tick period.
      if ((state_nxt != state) || (state == IDLE) || tick) presc <= '0;
      else                                                 presc <= presc + DIV_W'(1);
      if (state_nxt != state) hold_cnt <= '0;
      else if (hold_inc)      hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (load) begin
      div_s  <= step_div;
      hold_s <= hold_ticks;
      min_s  <= min_duty;
      max_s  <= max_duty;
    end
  end

`ifdef PWM_FADE_GAMMA_EN
  logic [15:0] gamma_prod;
  assign gamma_prod = {8'd0, duty} * ({8'd0, duty} + 16'd1);
  assign pwm_count  = gamma_prod[15:8];
`else
  assign pwm_count = duty;
`endif

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Scoreboard bench for pwm_fade_ctrl: a phase-list reference model predicts every cycle's outputs.
module tb_pwm_fade_ctrl;
  logic        clock = 1'b0;
  logic        reset, start, stop, loop_en;
  logic [15:0] step_div, hold_ticks;
  logic [7:0]  min_duty, max_duty;
  logic [7:0]  pwm_count;
  logic        busy, done, config_err;

  pwm_fade_ctrl #(.DIV_W(16), .HOLD_W(16)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .step_div(step_div), .hold_ticks(hold_ticks),
    .min_duty(min_duty), .max_duty(max_duty), .loop_en(loop_en),
    .pwm_count(pwm_count), .busy(busy), .done(done), .config_err(config_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int pwm;
    bit busy;
    bit done;
    bit cfg;
  } exp_t;

  exp_t sb[$];
  int   plan[$];
  bit   running;
  int   cur_duty;
  int   r_min, r_max, r_div, r_hold;
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic int gam(input int d);
`ifdef PWM_FADE_GAMMA_EN
    return (d * (d + 1)) >> 8;
`else
    return d;
`endif
  endfunction

  // One full min->max->min excursion as the list of duty values seen each cycle.
  task automatic build_phase();
    for (int d = r_min; d < r_max; d++)
      repeat (r_div + 1) plan.push_back(d);
    repeat ((r_hold + 1) * (r_div + 1)) plan.push_back(r_max);
    for (int d = r_max; d > r_min; d--)
      repeat (r_div + 1) plan.push_back(d);
    repeat ((r_hold + 1) * (r_div + 1)) plan.push_back(r_min);
  endtask

  task automatic set_cfg(input int mn, input int mx, input int dv, input int hl);
    min_duty   = 8'(mn);
    max_duty   = 8'(mx);
    step_div   = 16'(dv);
    hold_ticks = 16'(hl);
  endtask

  task automatic step(input bit rst, input bit st, input bit sp);
    exp_t e;
    reset = rst;
    start = st;
    stop  = sp;
    if (rst || sp) begin
      plan.delete();
      running  = 1'b0;
      cur_duty = 0;
      e = '{0, 1'b0, 1'b0, 1'b0};
    end else if (!running) begin
      if (st && (int'(min_duty) < int'(max_duty))) begin
        r_min = min_duty; r_max = max_duty; r_div = step_div; r_hold = hold_ticks;
        build_phase();
        running  = 1'b1;
        cur_duty = plan.pop_front();
        e = '{gam(cur_duty), 1'b1, 1'b0, 1'b0};
      end else begin
        e = '{gam(cur_duty), 1'b0, 1'b0, st};
      end
    end else if (plan.size() == 0) begin
      if (loop_en) begin
        build_phase();
        cur_duty = plan.pop_front();
        e = '{gam(cur_duty), 1'b1, 1'b0, 1'b0};
      end else begin
        running  = 1'b0;
        cur_duty = r_min;
        e = '{gam(cur_duty), 1'b0, 1'b1, 1'b0};
      end
    end else begin
      cur_duty = plan.pop_front();
      e = '{gam(cur_duty), 1'b1, 1'b0, 1'b0};
    end
    sb.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0);
  endtask

  exp_t mon_e;
  always @(negedge clock) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_tests++;
      if (pwm_count !== 8'(mon_e.pwm) || busy !== mon_e.busy ||
          done !== mon_e.done || config_err !== mon_e.cfg) begin
        n_fail++;
        $display("FAIL cycle_check t=%0t pwm=%0d want %0d busy=%0b want %0b done=%0b want %0b cfg_err=%0b want %0b",
                 $time, pwm_count, 8'(mon_e.pwm), busy, mon_e.busy, done, mon_e.done,
                 config_err, mon_e.cfg);
      end
    end
  end

  initial begin
    running = 1'b0; cur_duty = 0;
    loop_en = 1'b0;
    set_cfg(0, 3, 0, 0);
    // Power-on reset and idle
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    idle(3);
    // Short ramp, no prescale, no hold
    step(1'b0, 1'b1, 1'b0);
    idle(12);
    // Prescaled ramp
    set_cfg(0, 2, 3, 0);
    step(1'b0, 1'b1, 1'b0);
    idle(40);
    // Hold dwell
    set_cfg(3, 6, 1, 2);
    step(1'b0, 1'b1, 1'b0);
    idle(40);
    // Stop in IDLE after completion clears the held min duty
    step(1'b0, 1'b0, 1'b1);
    idle(2);
    // Stop mid-ramp at duty 5
    set_cfg(0, 20, 0, 0);
    step(1'b0, 1'b1, 1'b0);
    idle(5);
    step(1'b0, 1'b0, 1'b1);
    idle(3);
    // Rejected configurations
    set_cfg(10, 10, 0, 0);
    step(1'b0, 1'b1, 1'b0);
    idle(2);
    set_cfg(200, 9, 0, 0);
    step(1'b0, 1'b1, 1'b0);
    idle(2);
    // Start and stop together in IDLE
    set_cfg(1, 4, 0, 0);
    step(1'b0, 1'b1, 1'b1);
    idle(3);
    // Looping, then release the loop
    loop_en = 1'b1;
    set_cfg(0, 2, 0, 0);
    step(1'b0, 1'b1, 1'b0);
    idle(20);
    loop_en = 1'b0;
    idle(15);
    // Reset held mid-ramp
    set_cfg(0, 50, 1, 0);
    step(1'b0, 1'b1, 1'b0);
    idle(10);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    idle(3);
    // Extreme duty values (gamma corners: 128 and 255)
    set_cfg(127, 128, 0, 0);
    step(1'b0, 1'b1, 1'b0);
    idle(8);
    set_cfg(0, 255, 0, 0);
    step(1'b0, 1'b1, 1'b0);
    idle(520);
    // Randomized runs with config churn, stray starts, random stops and loop toggling
    for (int it = 0; it < 40; it++) begin
      int mn, mx, len;
      mn = $urandom_range(0, 250);
      mx = mn + $urandom_range(0, 12);
      if (mx > 255) mx = 255;
      if ($urandom_range(0, 9) == 0) mx = $urandom_range(0, 255);
      set_cfg(mn, mx, $urandom_range(0, 3), $urandom_range(0, 3));
      loop_en = 1'($urandom_range(0, 1));
      step(1'b0, 1'b1, 1'b0);
      len = $urandom_range(10, 200);
      for (int c = 0; c < len; c++) begin
        set_cfg($urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(0, 3), $urandom_range(0, 3));
        if ($urandom_range(0, 30) == 0) loop_en = ~loop_en;
        step(1'b0, ($urandom_range(0, 9) == 0), ($urandom_range(0, 80) == 0));
      end
      loop_en = 1'b0;
      step(1'b0, 1'b0, ($urandom_range(0, 1) == 1));
    end
    idle(2);
    for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clock);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain pending=%0d want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
